ps2_command_sequencer: RTL

- Host-to-keyboard command controller in front of the PS/2 transmit path; its responses share the receive path with the PS/2-to-XT scancode converter.
- Accepts one- or two-byte commands, e.g. FF reset or ED+LED mask, and hands bytes to the PS/2 byte transmitter.
- Waits for ACK FA, resends on FE or timeout, and reports done or error.
- While a command is in flight, it owns the receive path: it consumes response bytes and blocks scancode forwarding to the XT converter.

---
 rtl/ps2_command_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ps2_command_sequencer.sv
// PS/2 host-to-keyboard command sequencer: sends 1-2 byte commands, waits for
// ACK (FA), resends on FE/timeout, pulses cmd_done or cmd_error.
// Ports: clock/reset; cmd_* request; tx_* to byte transmitter;
// ps2_keycode/ps2_recive_flag/ps2_clear_keycode receive path;
// pass_enable grants the receive path to the XT converter.
module ps2_command_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_two_byte,
  input  logic [7:0] cmd_byte0,
  input  logic [7:0] cmd_byte1,
  output logic       cmd_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] ps2_keycode,
  input  logic       ps2_recive_flag,
  output logic       ps2_clear_keycode,
  output logic       pass_enable,
  output logic       cmd_done,
  output logic       cmd_error
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_TX, WAIT_ACK, RETRY, NEXT, DONE, ERROR
  } state_t;

  state_t        state, state_d;
  logic [7:0]    b0, b0_d, b1, b1_d;
  logic          two, two_d, sel, sel_d;
  logic [RW-1:0] retry, retry_d;
  logic [16:0]   tout, tout_d;
  logic          seen, seen_d, flag_q;
  logic [7:0]    tx_data_d;
  logic          tx_start_d, clear_d, done_d, error_d;
  logic          rise;

  assign rise        = ps2_recive_flag & ~flag_q;
  assign cmd_ready   = (state == IDLE);
  assign pass_enable = (state == IDLE);

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      b0                <= 8'h00;
      b1                <= 8'h00;
      two               <= 1'b0;
      sel               <= 1'b0;
      retry             <= '0;
      tout              <= '0;
      seen              <= 1'b0;
      flag_q            <= 1'b0;
      tx_data           <= 8'h00;
      tx_start          <= 1'b0;
      ps2_clear_keycode <= 1'b0;
      cmd_done          <= 1'b0;
      cmd_error         <= 1'b0;
    end else begin
      state             <= state_d;
      b0                <= b0_d;
      b1                <= b1_d;
      two               <= two_d;
      sel               <= sel_d;
      retry             <= retry_d;
      tout              <= tout_d;
      seen              <= seen_d;
      flag_q            <= ps2_recive_flag;
      tx_data           <= tx_data_d;
      tx_start          <= tx_start_d;
      ps2_clear_keycode <= clear_d;
      cmd_done          <= done_d;
      cmd_error         <= error_d;
    end
  end

  always_comb begin
    state_d    = state;
    b0_d       = b0;
    b1_d       = b1;
    two_d      = two;
    sel_d      = sel;
    retry_d    = retry;
    tout_d     = tout;
    seen_d     = seen;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    clear_d    = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          b0_d    = cmd_byte0;
          b1_d    = cmd_byte1;
          two_d   = cmd_two_byte;
          sel_d   = 1'b0;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d  = sel ? b1 : b0;
          tx_start_d = 1'b1;
          seen_d     = 1'b0;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // completion is the falling edge of busy, not merely busy low
        if (tx_busy) begin
          seen_d = 1'b1;
        end else if (seen) begin
          tout_d  = 17'(TIMEOUT_CYCLES);
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tout != '0) tout_d = tout - 17'd1;
        // a response in the expiring cycle wins over the timeout
        if (rise) begin
          clear_d = 1'b1;
          if (ps2_keycode == 8'hFA) state_d = NEXT;
          else if (ps2_keycode == 8'hFE) state_d = RETRY;
        end else if (tout == '0) begin
          state_d = RETRY;
        end
      end
      RETRY: begin
        if (retry == RW'(MAX_RETRY)) begin
          state_d = ERROR;
        end else begin
          retry_d = retry + 1'b1;
          state_d = SEND;
        end
      end
      NEXT: begin
        if (!sel && two) begin
          sel_d   = 1'b1;
          retry_d = '0;
          state_d = SEND;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
